stim_burst_sequencer: RTL and testbench

- Parametrised successor of the single-pair stimulation core: generates charge-balanced biphasic current pulses with amplitude ramp-up and ON/OFF burst gating for NCH electrode channels, time-multiplexed within each pulse period.
- Sits between the SPI configuration register file, which supplies parallel config words, and the analogue front end (H-bridge switch controls and current DAC code).
- Runs on the 20 kHz stimulation tick clock; one clk cycle = one 50 us tick.

---
 rtl/stim_burst_sequencer_if.sv | 54 +++++
 rtl/stim_burst_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_stim_burst_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stim_burst_sequencer_if.sv
// stim_burst_sequencer_if
//   Bundles the configuration word bus from the SPI register file and the
//   analogue front-end controls of stim_burst_sequencer.
//   master: register file / bench side (drives cfg_*, observes front-end controls)
//   slave : sequencer side (receives cfg_*, drives front-end controls)
//   Signals:
//     cfg_load, cfg_enable, cfg_amp, cfg_freq, cfg_phase, cfg_ramp, cfg_rf,
//     cfg_on, cfg_off, cfg_ele (channel i at [i*ELE_W +: ELE_W])
//     ele_sel, ph_a, ph_b, dac, chan, pulse_active, burst_on, cfg_err
interface stim_burst_sequencer_if #(
  parameter int NCH    = 2,
  parameter int ELE_W  = 32,
  parameter int AMP_W  = 6,
  parameter int FREQ_W = 12,
  parameter int PH_W   = 3,
  parameter int RAMP_W = 6,
  parameter int RF_W   = 10,
  parameter int ON_W   = 8,
  parameter int OFF_W  = 10
) ();
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 cfg_load;
  logic                 cfg_enable;
  logic [AMP_W-1:0]     cfg_amp;
  logic [FREQ_W-1:0]    cfg_freq;
  logic [PH_W-1:0]      cfg_phase;
  logic [RAMP_W-1:0]    cfg_ramp;
  logic [RF_W-1:0]      cfg_rf;
  logic [ON_W-1:0]      cfg_on;
  logic [OFF_W-1:0]     cfg_off;
  logic [NCH*ELE_W-1:0] cfg_ele;

  logic [ELE_W-1:0]     ele_sel;
  logic                 ph_a;
  logic                 ph_b;
  logic [AMP_W-1:0]     dac;
  logic [CH_W-1:0]      chan;
  logic                 pulse_active;
  logic                 burst_on;
  logic                 cfg_err;

  modport master (
    output cfg_load, cfg_enable, cfg_amp, cfg_freq, cfg_phase, cfg_ramp,
           cfg_rf, cfg_on, cfg_off, cfg_ele,
    input  ele_sel, ph_a, ph_b, dac, chan, pulse_active, burst_on, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_enable, cfg_amp, cfg_freq, cfg_phase, cfg_ramp,
           cfg_rf, cfg_on, cfg_off, cfg_ele,
    output ele_sel, ph_a, ph_b, dac, chan, pulse_active, burst_on, cfg_err
  );
endinterface

// File: rtl/stim_burst_sequencer.sv
// stim_burst_sequencer
//   Multi-channel biphasic stimulation sequencer with amplitude ramp and
//   ON/OFF burst gating. One clk cycle is one stimulation tick. Each period
//   fires channels 0..NCH-1 as PH1 / GAP / PH2 / DEAD, then waits out the
//   period. Configuration is latched into shadow registers on cfg_load and
//   adopted at period boundaries; enable acts immediately (current channel
//   finishes its pulse first).
//   Ports: clk, resetn (async, active low), bus (stim_burst_sequencer_if.slave)
//   Optional build macro RAMP_DOWN_EN: mirrored amplitude ramp-down at the end
//   of each finite ON window. Undefined: amplitude holds until the window ends.
module stim_burst_sequencer #(
  parameter int NCH    = 2,
  parameter int ELE_W  = 32,
  parameter int AMP_W  = 6,
  parameter int FREQ_W = 12,
  parameter int PH_W   = 3,
  parameter int RAMP_W = 6,
  parameter int RF_W   = 10,
  parameter int ON_W   = 8,
  parameter int OFF_W  = 10
) (
  input logic                  clk,
  input logic                  resetn,
  stim_burst_sequencer_if.slave bus
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_W = (((AMP_W + 4) > RF_W) ? (AMP_W + 4) : RF_W) + 1;
  localparam int N_W   = (ON_W > RAMP_W) ? ON_W : RAMP_W;

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_GAP, S_PH2, S_DEAD, S_WAIT, S_OFF} state_t;

  // Shadow copy of the configuration bus
  logic                 sh_en;
  logic [AMP_W-1:0]     sh_amp;
  logic [FREQ_W-1:0]    sh_freq;
  logic [PH_W-1:0]      sh_phase;
  logic [RAMP_W-1:0]    sh_ramp;
  logic [RF_W-1:0]      sh_rf;
  logic [ON_W-1:0]      sh_on;
  logic [OFF_W-1:0]     sh_off;
  logic [NCH*ELE_W-1:0] sh_ele;
  logic                 cfg_err_reg;

  // Configuration in force for the current period
  logic [FREQ_W-1:0]    act_freq;
  logic [PH_W-1:0]      act_phase;
  logic [ON_W-1:0]      act_on;
  logic [OFF_W-1:0]     act_off;
  logic [NCH*ELE_W-1:0] act_ele;

  state_t               state_reg;
  logic [FREQ_W:0]      tick_reg;
  logic [PH_W-1:0]      ph_cnt_reg;
  logic [CH_W-1:0]      chan_reg;
  logic [N_W-1:0]       pidx_reg;
  logic [OFF_W-1:0]     off_cnt_reg;
  logic [ACC_W-1:0]     acc_reg;
  logic [AMP_W-1:0]     amp_now_reg;
  logic [ELE_W-1:0]     ele_sel_reg;
  logic                 ph_a_reg, ph_b_reg, pulse_active_reg, burst_on_reg;
  logic [AMP_W-1:0]     dac_reg;

  logic [ELE_W-1:0] act_mask [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
    assign act_mask[gi] = act_ele[gi*ELE_W +: ELE_W];
  end

  // Phase width 0 is treated as 1; sequence length L = NCH*(2P+2)
  logic [PH_W-1:0] p_act, p_in;
  logic [FREQ_W:0] len_act, len_in, per_len;
  assign p_act   = (act_phase == '0) ? PH_W'(1) : act_phase;
  assign p_in    = (bus.cfg_phase == '0) ? PH_W'(1) : bus.cfg_phase;
  assign len_act = (FREQ_W+1)'(NCH * (2 * int'(p_act) + 2));
  assign len_in  = (FREQ_W+1)'(NCH * (2 * int'(p_in) + 2));
  // A too-short period is stretched to fit the whole channel sequence
  assign per_len = ({1'b0, act_freq} < len_act) ? len_act : {1'b0, act_freq};

  logic last_tick, ph_last, last_chan, win_end, off_last;
  logic [CH_W-1:0] next_chan;
  assign last_tick = (tick_reg == per_len - 1'b1);
  assign ph_last   = (ph_cnt_reg == p_act - 1'b1);
  assign last_chan = (chan_reg == CH_W'(NCH - 1));
  assign next_chan = chan_reg + 1'b1;
  assign win_end   = (act_on != '0) && (pidx_reg == N_W'(act_on) - N_W'(1));
  assign off_last  = (off_cnt_reg == act_off - 1'b1);

  // Ramp: next-period amplitude for a continuing window and for a fresh one.
  // Uses shadow values because they become active at the same boundary.
  logic [ACC_W-1:0] amp_lim, sum_cont, acc_cont, acc_fresh;
  logic [AMP_W-1:0] amp_cont, amp_fresh;
  logic [N_W-1:0]   n_cont;
`ifdef RAMP_DOWN_EN
  logic [N_W-1:0]   on_n, rmp_n, down_start;
`endif
  always_comb begin
    amp_lim   = ACC_W'({sh_amp, 4'b0000});
    n_cont    = (&pidx_reg) ? pidx_reg : pidx_reg + 1'b1;
    sum_cont  = acc_reg + ACC_W'(sh_rf);
    acc_cont  = (sum_cont > amp_lim) ? amp_lim : sum_cont;
    acc_fresh = (ACC_W'(sh_rf) > amp_lim) ? amp_lim : ACC_W'(sh_rf);
    amp_cont  = ((sh_ramp == '0) || (n_cont >= N_W'(sh_ramp))) ? sh_amp : acc_cont[AMP_W+3:4];
    amp_fresh = (sh_ramp == '0) ? sh_amp : acc_fresh[AMP_W+3:4];
`ifdef RAMP_DOWN_EN
    on_n       = N_W'(sh_on);
    rmp_n      = N_W'(sh_ramp);
    down_start = (on_n > rmp_n) ? on_n - rmp_n : '0;
    if ((sh_on != '0) && (sh_ramp != '0)) begin
      if (n_cont >= down_start) begin
        acc_cont = (acc_reg > ACC_W'(sh_rf)) ? acc_reg - ACC_W'(sh_rf) : '0;
        amp_cont = (acc_cont > amp_lim) ? sh_amp : acc_cont[AMP_W+3:4];
      end
      if (down_start == '0) begin
        acc_fresh = '0;
        amp_fresh = '0;
      end
    end
`endif
  end

  // Boundary / exit decisions, prioritised in the FSM below
  logic start_fresh, start_cont, enter_off, enter_idle, period_end;
  always_comb begin
    start_fresh = 1'b0;
    start_cont  = 1'b0;
    enter_off   = 1'b0;
    enter_idle  = 1'b0;
    period_end  = 1'b0;
    case (state_reg)
      S_IDLE: start_fresh = sh_en;
      S_PH2:  enter_idle  = ph_last && !sh_en;
      S_DEAD: if (!sh_en) enter_idle = 1'b1;
              else if (last_chan && last_tick) period_end = 1'b1;
      S_WAIT: if (!sh_en) enter_idle = 1'b1;
              else if (last_tick) period_end = 1'b1;
      S_OFF:  if (!sh_en) enter_idle = 1'b1;
              else if (last_tick && off_last) start_fresh = 1'b1;
      default: ;
    endcase
    if (period_end) begin
      if (win_end && (sh_off != '0)) enter_off   = 1'b1;
      else if (win_end)              start_fresh = 1'b1;  // no OFF window, ramp restarts
      else                           start_cont  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_en <= 1'b0; sh_amp <= '0; sh_freq <= '0; sh_phase <= '0; sh_ramp <= '0;
      sh_rf <= '0; sh_on <= '0; sh_off <= '0; sh_ele <= '0; cfg_err_reg <= 1'b0;
    end else if (bus.cfg_load) begin
      sh_en <= bus.cfg_enable; sh_amp <= bus.cfg_amp; sh_freq <= bus.cfg_freq;
      sh_phase <= bus.cfg_phase; sh_ramp <= bus.cfg_ramp; sh_rf <= bus.cfg_rf;
      sh_on <= bus.cfg_on; sh_off <= bus.cfg_off; sh_ele <= bus.cfg_ele;
      cfg_err_reg <= ({1'b0, bus.cfg_freq} < len_in);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE; tick_reg <= '0; ph_cnt_reg <= '0; chan_reg <= '0;
      pidx_reg <= '0; off_cnt_reg <= '0; acc_reg <= '0; amp_now_reg <= '0;
      act_freq <= '0; act_phase <= '0; act_on <= '0; act_off <= '0; act_ele <= '0;
      ele_sel_reg <= '0; ph_a_reg <= 1'b0; ph_b_reg <= 1'b0; dac_reg <= '0;
      pulse_active_reg <= 1'b0; burst_on_reg <= 1'b0;
    end else if (enter_idle) begin
      state_reg <= S_IDLE; tick_reg <= '0; ph_cnt_reg <= '0; chan_reg <= '0;
      pidx_reg <= '0; off_cnt_reg <= '0; acc_reg <= '0; amp_now_reg <= '0;
      ele_sel_reg <= '0; ph_a_reg <= 1'b0; ph_b_reg <= 1'b0; dac_reg <= '0;
      pulse_active_reg <= 1'b0; burst_on_reg <= 1'b0;
    end else if (start_fresh || start_cont) begin
      // New period: adopt shadow config and open channel 0 PH1
      act_freq <= sh_freq; act_phase <= sh_phase; act_on <= sh_on;
      act_off <= sh_off; act_ele <= sh_ele;
      state_reg <= S_PH1; tick_reg <= '0; ph_cnt_reg <= '0; chan_reg <= '0;
      off_cnt_reg <= '0;
      pidx_reg    <= start_fresh ? '0 : n_cont;
      acc_reg     <= start_fresh ? acc_fresh : acc_cont;
      amp_now_reg <= start_fresh ? amp_fresh : amp_cont;
      dac_reg     <= start_fresh ? amp_fresh : amp_cont;
      ele_sel_reg <= sh_ele[ELE_W-1:0];
      ph_a_reg <= 1'b1; ph_b_reg <= 1'b0; pulse_active_reg <= 1'b1; burst_on_reg <= 1'b1;
    end else if (enter_off) begin
      act_freq <= sh_freq; act_phase <= sh_phase; act_on <= sh_on;
      act_off <= sh_off; act_ele <= sh_ele;
      state_reg <= S_OFF; tick_reg <= '0; off_cnt_reg <= '0; chan_reg <= '0;
      ele_sel_reg <= '0; ph_a_reg <= 1'b0; ph_b_reg <= 1'b0; dac_reg <= '0;
      pulse_active_reg <= 1'b0; burst_on_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_PH1: begin
          tick_reg <= tick_reg + 1'b1;
          if (ph_last) begin
            state_reg <= S_GAP; ph_a_reg <= 1'b0; dac_reg <= '0;
          end else begin
            ph_cnt_reg <= ph_cnt_reg + 1'b1;
          end
        end
        S_GAP: begin
          tick_reg <= tick_reg + 1'b1;
          state_reg <= S_PH2; ph_cnt_reg <= '0; ph_b_reg <= 1'b1; dac_reg <= amp_now_reg;
        end
        S_PH2: begin
          tick_reg <= tick_reg + 1'b1;
          if (ph_last) begin
            state_reg <= S_DEAD; ph_b_reg <= 1'b0; dac_reg <= '0;
            ele_sel_reg <= '0; pulse_active_reg <= 1'b0;
          end else begin
            ph_cnt_reg <= ph_cnt_reg + 1'b1;
          end
        end
        S_DEAD: begin
          tick_reg <= tick_reg + 1'b1;
          if (last_chan) begin
            state_reg <= S_WAIT;
          end else begin
            state_reg <= S_PH1; chan_reg <= next_chan; ph_cnt_reg <= '0;
            ele_sel_reg <= act_mask[next_chan]; ph_a_reg <= 1'b1;
            dac_reg <= amp_now_reg; pulse_active_reg <= 1'b1;
          end
        end
        S_WAIT: tick_reg <= tick_reg + 1'b1;
        S_OFF: begin
          if (last_tick) begin
            tick_reg <= '0; off_cnt_reg <= off_cnt_reg + 1'b1;
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        default: tick_reg <= '0;
      endcase
    end
  end

  assign bus.ele_sel      = ele_sel_reg;
  assign bus.ph_a         = ph_a_reg;
  assign bus.ph_b         = ph_b_reg;
  assign bus.dac          = dac_reg;
  assign bus.chan         = chan_reg;
  assign bus.pulse_active = pulse_active_reg;
  assign bus.burst_on     = burst_on_reg;
  assign bus.cfg_err      = cfg_err_reg;
endmodule

// File: tb/tb_stim_burst_sequencer.sv
// Directed bench for stim_burst_sequencer. Tick t = cycle index relative to
// the first tick of period 0 of the current run.
module tb_stim_burst_sequencer;
  localparam int NCH = 2, ELE_W = 32, AMP_W = 6, FREQ_W = 12, PH_W = 3;
  localparam int RAMP_W = 6, RF_W = 10, ON_W = 8, OFF_W = 10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t = 0;

  always #5 clk = ~clk;

  stim_burst_sequencer_if #(.NCH(NCH), .ELE_W(ELE_W), .AMP_W(AMP_W), .FREQ_W(FREQ_W),
    .PH_W(PH_W), .RAMP_W(RAMP_W), .RF_W(RF_W), .ON_W(ON_W), .OFF_W(OFF_W)) bus ();

  stim_burst_sequencer #(.NCH(NCH), .ELE_W(ELE_W), .AMP_W(AMP_W), .FREQ_W(FREQ_W),
    .PH_W(PH_W), .RAMP_W(RAMP_W), .RF_W(RF_W), .ON_W(ON_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    t += n;
  endtask

  task automatic goto(input int tt);
    if (tt > t) step(tt - t);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    $display("check %-12s t=%0d obs=0x%0h exp=0x%0h", tag, t, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at t=%0d: observed 0x%0h expected 0x%0h", tag, t, obs, exp);
    end
  endtask

  task automatic load(input logic [AMP_W-1:0] amp, input logic [FREQ_W-1:0] freq,
                      input logic [PH_W-1:0] ph, input logic [RAMP_W-1:0] ramp,
                      input logic [RF_W-1:0] rf, input logic [ON_W-1:0] on,
                      input logic [OFF_W-1:0] off, input logic en);
    bus.cfg_amp = amp; bus.cfg_freq = freq; bus.cfg_phase = ph; bus.cfg_ramp = ramp;
    bus.cfg_rf = rf; bus.cfg_on = on; bus.cfg_off = off; bus.cfg_enable = en;
    bus.cfg_load = 1'b1;
    step(1);
    bus.cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  initial begin
    bus.cfg_load = 1'b0; bus.cfg_enable = 1'b0; bus.cfg_amp = '0; bus.cfg_freq = '0;
    bus.cfg_phase = '0; bus.cfg_ramp = '0; bus.cfg_rf = '0; bus.cfg_on = '0; bus.cfg_off = '0;
    bus.cfg_ele = {32'h0000_4000, 32'h0000_8000};
    do_reset();
    step(2);
    chk("rst_ele", bus.ele_sel, 0);
    chk("rst_pha", bus.ph_a, 0);
    chk("rst_phb", bus.ph_b, 0);
    chk("rst_dac", bus.dac, 0);
    chk("rst_chan", bus.chan, 0);
    chk("rst_pulse", bus.pulse_active, 0);
    chk("rst_burst", bus.burst_on, 0);
    chk("rst_err", bus.cfg_err, 0);

    // Basic two-channel period, no ramp, continuous
    load(25, 400, 4, 0, 0, 0, 0, 1'b1); t = -1;
    goto(0);   chk("p1_pha", bus.ph_a, 1); chk("p1_phb", bus.ph_b, 0);
               chk("p1_ele", bus.ele_sel, 32'h8000); chk("p1_dac", bus.dac, 25);
               chk("p1_chan", bus.chan, 0); chk("p1_pulse", bus.pulse_active, 1);
               chk("p1_burst", bus.burst_on, 1);
    goto(3);   chk("p1_end", bus.ph_a, 1);
    goto(4);   chk("gap_pha", bus.ph_a, 0); chk("gap_phb", bus.ph_b, 0);
               chk("gap_dac", bus.dac, 0); chk("gap_ele", bus.ele_sel, 32'h8000);
               chk("gap_pulse", bus.pulse_active, 1);
    goto(5);   chk("p2_phb", bus.ph_b, 1); chk("p2_dac", bus.dac, 25);
    goto(8);   chk("p2_end", bus.ph_b, 1);
    goto(9);   chk("dead_ele", bus.ele_sel, 0); chk("dead_pulse", bus.pulse_active, 0);
               chk("dead_phb", bus.ph_b, 0); chk("dead_burst", bus.burst_on, 1);
    goto(10);  chk("c1_pha", bus.ph_a, 1); chk("c1_ele", bus.ele_sel, 32'h4000);
               chk("c1_chan", bus.chan, 1); chk("c1_dac", bus.dac, 25);
    goto(13);  chk("c1_p1end", bus.ph_a, 1);
    goto(14);  chk("c1_gap", bus.ph_a, 0);
    goto(20);  chk("wait_pulse", bus.pulse_active, 0); chk("wait_ele", bus.ele_sel, 0);
    goto(399); chk("wait_last", bus.ph_a, 0);
    goto(400); chk("per1_pha", bus.ph_a, 1); chk("per1_chan", bus.chan, 0);
               chk("per1_ele", bus.ele_sel, 32'h8000);
    do_reset();

    // Ramp: 50 periods, rf = 0.5 per period
    load(25, 400, 4, 50, 8, 0, 0, 1'b1); t = -1;
    goto(0);     chk("rmp_n0", bus.dac, 0); chk("rmp_n0_pha", bus.ph_a, 1);
    goto(400);   chk("rmp_n1", bus.dac, 1);
    goto(405);   chk("rmp_n1_p2", bus.dac, 1); chk("rmp_n1_phb", bus.ph_b, 1);
    goto(9200);  chk("rmp_n23", bus.dac, 12);
    goto(19200); chk("rmp_n48", bus.dac, 24);
    goto(19600); chk("rmp_n49", bus.dac, 25);
    goto(20000); chk("rmp_n50", bus.dac, 25);
    do_reset();

    // Burst gating: 50 ON / 50 OFF periods of 40 ticks
    load(25, 40, 4, 0, 0, 50, 50, 1'b1); t = -1;
    goto(0);    chk("b_on0", bus.burst_on, 1);
    goto(1999); chk("b_onlast", bus.burst_on, 1);
    goto(2000); chk("b_off0", bus.burst_on, 0); chk("b_off0_pulse", bus.pulse_active, 0);
    goto(2010); chk("b_off_pha", bus.ph_a, 0); chk("b_off_ele", bus.ele_sel, 0);
    goto(3999); chk("b_offlast", bus.burst_on, 0);
    goto(4000); chk("b_on2", bus.burst_on, 1); chk("b_on2_pha", bus.ph_a, 1);
                chk("b_on2_ele", bus.ele_sel, 32'h8000);
    do_reset();

    // Ramp restart after OFF: rf = 1.0, 3 ON / 2 OFF
    load(25, 40, 4, 10, 16, 3, 2, 1'b1); t = -1;
    goto(0);   chk("rr_n0", bus.dac, 1);
    goto(80);  chk("rr_n2", bus.dac, 3);
    goto(120); chk("rr_off", bus.burst_on, 0);
    goto(200); chk("rr_again", bus.dac, 1); chk("rr_burst", bus.burst_on, 1);
    do_reset();

    // Too-short period: stretched to L = 20, error sticky until legal load
    load(25, 10, 4, 0, 0, 0, 0, 1'b1); t = -1;
    chk("err_set", bus.cfg_err, 1);
    goto(0);  chk("err_p0", bus.ph_a, 1);
    goto(19); chk("err_dead", bus.pulse_active, 0); chk("err_dchan", bus.chan, 1);
    goto(20); chk("err_p1", bus.ph_a, 1); chk("err_p1chan", bus.chan, 0);
              chk("err_hold", bus.cfg_err, 1);
    load(25, 400, 4, 0, 0, 0, 0, 1'b1);
    chk("err_clr", bus.cfg_err, 0);
    do_reset();

    // Disable at ch0 PH1 tick 2
    load(25, 400, 4, 0, 0, 0, 0, 1'b1); t = -1;
    goto(2);
    load(25, 400, 4, 0, 0, 0, 0, 1'b0);
    chk("dis_t3", bus.ph_a, 1);
    goto(4);  chk("dis_gap", bus.ph_a, 0); chk("dis_gap_pulse", bus.pulse_active, 1);
    goto(5);  chk("dis_p2", bus.ph_b, 1); chk("dis_p2dac", bus.dac, 25);
    goto(8);  chk("dis_p2end", bus.ph_b, 1);
    goto(9);  chk("dis_phb", bus.ph_b, 0); chk("dis_ele", bus.ele_sel, 0);
              chk("dis_dac", bus.dac, 0); chk("dis_pulse", bus.pulse_active, 0);
              chk("dis_burst", bus.burst_on, 0);
    goto(10); chk("dis_noch1", bus.ph_a, 0); chk("dis_noch1e", bus.ele_sel, 0);
    do_reset();

    // Asynchronous reset during ch1 PH2, then restart from period 0
    load(25, 40, 4, 50, 8, 0, 0, 1'b1); t = -1;
    goto(96); chk("ar_phb", bus.ph_b, 1); chk("ar_chan", bus.chan, 1); chk("ar_dac", bus.dac, 1);
    #1 resetn = 1'b0;
    #1;
    chk("ar_phb0", bus.ph_b, 0); chk("ar_dac0", bus.dac, 0); chk("ar_ele0", bus.ele_sel, 0);
    chk("ar_pulse0", bus.pulse_active, 0); chk("ar_burst0", bus.burst_on, 0);
    chk("ar_chan0", bus.chan, 0);
    step(2);
    resetn = 1'b1;
    step(1);
    load(25, 40, 4, 50, 8, 0, 0, 1'b1); t = -1;
    goto(0);  chk("ar_rs_pha", bus.ph_a, 1); chk("ar_rs_dac", bus.dac, 0);
              chk("ar_rs_chan", bus.chan, 0); chk("ar_rs_ele", bus.ele_sel, 32'h8000);
    goto(40); chk("ar_rs_n1", bus.dac, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
